// File: rtl/mod_updown_counter.sv
`timescale 1ns/1ps
// mod_updown_counter
// Modulo-N up/down counter with synchronous clear, clamped parallel load,
// cascading terminal-count, one-cycle wrap pulse and a sticky overflow flag.
//
// Parameters
//   WIDTH    counter width in bits (2..16)
//   MODULUS  count modulus (2..2**WIDTH); the counter runs 0..MODULUS-1
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset
//   en        in   count enable
//   up        in   direction: 1 = up, 0 = down
//   clr       in   synchronous clear to 0 (highest priority)
//   load      in   synchronous parallel load of load_val
//   load_val  in   value to load; values >= MODULUS clamp to MODULUS-1
//   ovf_clr   in   clears the sticky overflow flag
//   cnt       out  registered count
//   tc        out  combinational terminal count (en and at the wrap point)
//   wrap      out  registered pulse, high the cycle after a count wrapped
//   ovf       out  registered sticky wrap flag
//   cnt_gray  out  Gray-coded view of cnt; present only when the macro
//                  MOD_UPDOWN_COUNTER_GRAY_EN is defined
module mod_updown_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
    ,
    output logic [WIDTH-1:0] cnt_gray
`endif
);

    // Reject illegal configurations at elaboration time.
    generate
        if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
            $fatal(1, "mod_updown_counter: WIDTH must be in 2..16");
        end
        if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
            $fatal(1, "mod_updown_counter: MODULUS must be in 2..2**WIDTH");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    // One extra bit so MODULUS == 2**WIDTH is representable.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] cnt_next;
    logic             wrap_next;
    logic             ovf_next;
    logic             load_in_range;

    assign load_in_range = ({1'b0, load_val} < MOD_EXT);

    // Terminal count looks only at en/up/cnt so a cascaded stage sees it
    // in the same cycle, regardless of any pending clr or load.
    assign tc = en & (up ? (cnt == MAX_VAL) : (cnt == '0));

    always_comb begin
        // NOTE: every output of this block gets a default first, so no
        // path through the if/else chain can leave a latch behind.
        cnt_next  = cnt;
        wrap_next = 1'b0;
        if (clr) begin
            cnt_next = '0;
        end else if (load) begin
            cnt_next = load_in_range ? load_val : MAX_VAL;
        end else if (en) begin
            if (up) begin
                if (cnt == MAX_VAL) begin
                    cnt_next  = '0;
                    wrap_next = 1'b1;
                end else begin
                    cnt_next = cnt + ONE;
                end
            end else begin
                if (cnt == '0) begin
                    cnt_next  = MAX_VAL;
                    wrap_next = 1'b1;
                end else begin
                    cnt_next = cnt - ONE;
                end
            end
        end
    end

    // A wrap on the same edge as ovf_clr wins, so no overflow is ever lost.
    assign ovf_next = wrap_next | (ovf & ~ovf_clr);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            wrap <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            cnt  <= cnt_next;
            wrap <= wrap_next;
            ovf  <= ovf_next;
        end
    end

`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
    // Derived straight from the cnt register, so it is 0 while in reset.
    assign cnt_gray = cnt ^ (cnt >> 1);
`endif

endmodule

// File: tb/tb_mod_updown_counter.sv
`timescale 1ns/1ps
// Testbench for mod_updown_counter. Two instances (MODULUS=10 and 16,
// WIDTH=4) share one stimulus stream; an arithmetic reference model tracks
// both, and a directed vector table pins down the MODULUS=10 corner cases.
module tb_mod_updown_counter;

    logic clk = 1'b0;
    logic rst;
    logic en, up, clr, load, ovf_clr;
    logic [3:0] load_val;

    logic [1:0][3:0] cnt_o;
    logic [1:0]      tc_o, wrap_o, ovf_o;
`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
    logic [1:0][3:0] gray_o;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model state, one slot per instance.
    int mod_of [2] = '{10, 16};
    int m_cnt  [2];
    bit m_wrap [2];
    bit m_ovf  [2];

    always #5 clk = ~clk;

    mod_updown_counter #(.WIDTH(4), .MODULUS(10)) u_dut10 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr),
        .cnt(cnt_o[0]), .tc(tc_o[0]), .wrap(wrap_o[0]), .ovf(ovf_o[0])
`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
        , .cnt_gray(gray_o[0])
`endif
    );

    mod_updown_counter #(.WIDTH(4), .MODULUS(16)) u_dut16 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr),
        .cnt(cnt_o[1]), .tc(tc_o[1]), .wrap(wrap_o[1]), .ovf(ovf_o[1])
`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
        , .cnt_gray(gray_o[1])
`endif
    );

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_cnt[d]  = 0;
            m_wrap[d] = 1'b0;
            m_ovf[d]  = 1'b0;
        end
    endtask

    // One clock edge of the specified behaviour, in plain modular arithmetic.
    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            int m;
            bit w;
            m = mod_of[d];
            w = 1'b0;
            if (clr)
                m_cnt[d] = 0;
            else if (load)
                m_cnt[d] = (int'(load_val) >= m) ? m - 1 : int'(load_val);
            else if (en) begin
                if (up) begin
                    w = (m_cnt[d] + 1 == m);
                    m_cnt[d] = (m_cnt[d] + 1) % m;
                end else begin
                    w = (m_cnt[d] == 0);
                    m_cnt[d] = (m_cnt[d] + m - 1) % m;
                end
            end
            m_wrap[d] = w;
            m_ovf[d]  = w || (m_ovf[d] && !ovf_clr);
        end
    endtask

    task automatic compare_regs(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s cnt[m%0d]", tag, mod_of[d]), int'(cnt_o[d]), m_cnt[d]);
            check($sformatf("%s wrap[m%0d]", tag, mod_of[d]), int'(wrap_o[d]), int'(m_wrap[d]));
            check($sformatf("%s ovf[m%0d]", tag, mod_of[d]), int'(ovf_o[d]), int'(m_ovf[d]));
`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
            check($sformatf("%s gray[m%0d]", tag, mod_of[d]), int'(gray_o[d]),
                  m_cnt[d] ^ (m_cnt[d] / 2));
`endif
        end
    endtask

    // Called away from a clock edge with inputs already set: checks tc before
    // the edge, advances one edge, then checks registered outputs.
    task automatic step(input string tag, output logic tc10_pre);
        #1;
        tc10_pre = tc_o[0];
        for (int d = 0; d < 2; d++) begin
            int exp_tc;
            exp_tc = (en && (up ? (m_cnt[d] == mod_of[d] - 1) : (m_cnt[d] == 0))) ? 1 : 0;
            check($sformatf("%s tc[m%0d]", tag, mod_of[d]), int'(tc_o[d]), exp_tc);
        end
        @(posedge clk);
        if (rst) model_edge();
        #1;
        compare_regs(tag);
    endtask

    task automatic set_in(input bit e, input bit u, input bit c, input bit l,
                          input int lv, input bit oc);
        en = e; up = u; clr = c; load = l; load_val = 4'(lv); ovf_clr = oc;
    endtask

    // Asynchronous reset held over a clock edge, released between edges.
    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        model_reset();
        #1;
        compare_regs("reset");
        @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        bit en, up, clr, load, ovf_clr;
        int lv;
        int tc, cnt, wrap, ovf;   // expected: tc before edge, regs after edge
    } vec_t;

    vec_t tbl [16];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic tcp;
        logic [3:0] prev_gray;

        // Directed vectors for the MODULUS=10 instance, starting from reset.
        //            en up clr ld oc  lv   tc cnt wr ovf
        tbl[0]  = '{0, 0, 0, 1, 0, 13,  0, 9, 0, 0};  // load clamps 13 -> 9
        tbl[1]  = '{1, 1, 0, 0, 0,  0,  1, 0, 1, 1};  // 9 -> 0 up wrap
        tbl[2]  = '{1, 0, 0, 0, 0,  0,  1, 9, 1, 1};  // 0 -> 9 down wrap
        tbl[3]  = '{1, 0, 0, 0, 1,  0,  0, 8, 0, 0};  // ovf_clr alone
        tbl[4]  = '{1, 0, 1, 1, 0,  5,  0, 0, 0, 0};  // clr beats load
        tbl[5]  = '{1, 0, 0, 0, 1,  0,  1, 9, 1, 1};  // wrap + ovf_clr keeps ovf
        tbl[6]  = '{0, 0, 0, 0, 1,  0,  0, 9, 0, 0};  // ovf_clr alone clears
        tbl[7]  = '{1, 1, 0, 1, 0,  9,  1, 9, 0, 0};  // load at tc: no wrap
        tbl[8]  = '{1, 1, 1, 0, 0,  0,  1, 0, 0, 0};  // clr at tc: no wrap
        tbl[9]  = '{0, 1, 0, 1, 0, 15,  0, 9, 0, 0};  // clamp 15 -> 9
        tbl[10] = '{0, 1, 0, 0, 0,  0,  0, 9, 0, 0};  // en=0 holds
        tbl[11] = '{1, 1, 0, 0, 0,  0,  1, 0, 1, 1};  // up wrap
        tbl[12] = '{0, 1, 0, 1, 0, 10,  0, 9, 0, 1};  // clamp 10 -> 9
        tbl[13] = '{0, 1, 0, 1, 0,  3,  0, 3, 0, 1};  // in-range load
        tbl[14] = '{1, 0, 0, 0, 0,  0,  0, 2, 0, 1};  // down
        tbl[15] = '{1, 1, 0, 0, 0,  0,  0, 3, 0, 1};  // reverse: no skip

        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0);
        do_reset();

        foreach (tbl[i]) begin
            set_in(tbl[i].en, tbl[i].up, tbl[i].clr, tbl[i].load, tbl[i].lv, tbl[i].ovf_clr);
            step($sformatf("vec%0d", i), tcp);
            check($sformatf("vec%0d tc", i),   int'(tcp),       tbl[i].tc);
            check($sformatf("vec%0d cnt", i),  int'(cnt_o[0]),  tbl[i].cnt);
            check($sformatf("vec%0d wrap", i), int'(wrap_o[0]), tbl[i].wrap);
            check($sformatf("vec%0d ovf", i),  int'(ovf_o[0]),  tbl[i].ovf);
        end

        // Up count from reset: 1..9,0,1,2 with wrap/tc/ovf at the 9 -> 0 step.
        do_reset();
        set_in(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            step($sformatf("up%0d", i), tcp);
            check($sformatf("up%0d tc", i),   int'(tcp),       (i == 9) ? 1 : 0);
            check($sformatf("up%0d cnt", i),  int'(cnt_o[0]),  (i + 1) % 10);
            check($sformatf("up%0d wrap", i), int'(wrap_o[0]), (i == 9) ? 1 : 0);
            check($sformatf("up%0d ovf", i),  int'(ovf_o[0]),  (i >= 9) ? 1 : 0);
        end

        // Async reset between edges at cnt=5, then first count after release.
        do_reset();
        set_in(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step("pre_rst", tcp);
        check("cnt before async reset", int'(cnt_o[0]), 5);
        en = 1'b0;
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("async rst cnt",  int'(cnt_o[0]), 0);
        check("async rst wrap", int'(wrap_o[0]), 0);
        check("async rst ovf",  int'(ovf_o[0]), 0);
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b1;
        step("first_after_rst", tcp);
        check("first count after release", int'(cnt_o[0]), 1);

        // Reset held over an edge discards a pending load.
        set_in(0, 1, 0, 1, 7, 0);
        rst = 1'b0;
        model_reset();
        step("rst_over_load", tcp);
        check("load discarded by reset", int'(cnt_o[0]), 0);
        set_in(0, 1, 0, 0, 0, 0);
        rst = 1'b1;
        step("hold_after_rst", tcp);

`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
        // Full up sweep on MODULUS=16: exactly one Gray bit flips per step.
        do_reset();
        set_in(1, 1, 0, 0, 0, 0);
        #1;
        prev_gray = gray_o[1];
        for (int i = 0; i < 17; i++) begin
            step($sformatf("gray%0d", i), tcp);
            check($sformatf("gray%0d bit flips", i), $countones(prev_gray ^ gray_o[1]), 1);
            prev_gray = gray_o[1];
        end
`endif

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                   int'($urandom_range(0, 15)), $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 63) == 0) begin
                #2;
                rst = 1'b0;
                model_reset();
                #1;
                compare_regs("rand_rst");
                rst = 1'b1;
            end
            step($sformatf("rand%0d", i), tcp);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
